// File: rtl/red_pitaya_acq_ch.sv
// Single-channel ADC acquisition: decimate/average, circular capture buffer,
// level/sw/ext trigger, post-trigger countdown and registered read-back.
module red_pitaya_acq_ch #(
  parameter int RSZ = 14
) (
  input  logic           adc_clk_i,
  input  logic           adc_rstn_i,
  input  logic [13:0]    adc_dat_i,
  input  logic           trig_sw_i,
  input  logic           trig_ext_i,
  input  logic [2:0]     trig_src_i,
  input  logic           set_arm_i,
  input  logic           set_rst_i,
  input  logic [16:0]    set_dec_i,
  input  logic           set_avg_i,
  input  logic [13:0]    set_tresh_i,
  input  logic [13:0]    set_hyst_i,
  input  logic [31:0]    set_dly_i,
  input  logic [RSZ-1:0] buf_addr_i,
  output logic [13:0]    buf_rdata_o,
  output logic [RSZ-1:0] wp_cur_o,
  output logic [RSZ-1:0] wp_trig_o,
  output logic           trig_o,
  output logic           armed_o,
  output logic           done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] SRC_SW   = 3'd1;
  localparam logic [2:0] SRC_LVLP = 3'd2;
  localparam logic [2:0] SRC_LVLN = 3'd3;
  localparam logic [2:0] SRC_EXTP = 3'd4;
  localparam logic [2:0] SRC_EXTN = 3'd5;

  state_t state_q, state_d;

  logic [13:0]        adc_q, adc_d;
  logic [16:0]        dec_cnt_q, dec_cnt_d;
  logic signed [30:0] sum_q, sum_d;
  logic [13:0]        dec_dat_q, dec_dat_d;
  logic               dec_vld_q, dec_vld_d;
  logic               dec_trg_q, dec_trg_d;
  logic               ext_s1_q, ext_s1_d;
  logic               ext_s2_q, ext_s2_d;
  logic               ext_s3_q, ext_s3_d;
  logic               pend_q, pend_d;
  logic               lvl_armp_q, lvl_armp_d;
  logic [RSZ-1:0]     wp_q, wp_d;
  logic [RSZ-1:0]     wp_trig_q, wp_trig_d;
  logic [31:0]        dly_q, dly_d;
  logic               trig_q, trig_d;
  logic [13:0]        rdata_q, rdata_d;

  logic [13:0]        mem [2**RSZ];

  logic [16:0]        dec_len;
  logic               strobe;
  logic               strobe_eff;
  logic               clr;
  logic [4:0]         avg_sh;
  logic               avg_ok;
  logic signed [30:0] sum_tot;
  logic [13:0]        samp;
  logic signed [15:0] samp_w;
  logic signed [15:0] tr_w;
  logic signed [15:0] hy_w;
  logic signed [15:0] lvl_lo;
  logic signed [15:0] lvl_hi;
  logic               lvl_fire;
  logic               ext_rise;
  logic               ext_fall;
  logic               src_hit;
  logic               we;

  // Decimator, averager and trigger qualification, all ahead of the write stage.
  always_comb begin
    adc_d    = adc_dat_i;
    dec_len  = (set_dec_i == 17'd0) ? 17'd1 : set_dec_i;
    strobe   = (dec_cnt_q >= (dec_len - 17'd1));
    clr      = set_rst_i | set_arm_i;
    strobe_eff = strobe & ~clr;

    avg_ok = 1'b1;
    avg_sh = 5'd0;
    case (dec_len)
      17'd1:     avg_sh = 5'd0;
      17'd8:     avg_sh = 5'd3;
      17'd64:    avg_sh = 5'd6;
      17'd1024:  avg_sh = 5'd10;
      17'd8192:  avg_sh = 5'd13;
      17'd65536: avg_sh = 5'd16;
      default:   avg_ok = 1'b0;
    endcase

    sum_tot = sum_q + {{17{adc_q[13]}}, adc_q};
    samp    = (set_avg_i && avg_ok) ? 14'(sum_tot >>> avg_sh) : adc_q;

    if (clr || strobe) begin
      dec_cnt_d = 17'd0;
      sum_d     = '0;
    end else begin
      dec_cnt_d = dec_cnt_q + 17'd1;
      sum_d     = sum_tot;
    end

    // 16-bit compare keeps tresh -/+ hyst from wrapping at the range limits.
    samp_w = {{2{samp[13]}}, samp};
    tr_w   = {{2{set_tresh_i[13]}}, set_tresh_i};
    hy_w   = {2'b00, set_hyst_i};
    lvl_lo = tr_w - hy_w;
    lvl_hi = tr_w + hy_w;

    lvl_fire   = 1'b0;
    lvl_armp_d = lvl_armp_q;
    if (trig_src_i == SRC_LVLP) begin
      if (strobe_eff) begin
        if (samp_w < lvl_lo) begin
          lvl_armp_d = 1'b1;
        end else if (lvl_armp_q && (samp_w >= tr_w)) begin
          lvl_fire   = 1'b1;
          lvl_armp_d = 1'b0;
        end
      end
    end else if (trig_src_i == SRC_LVLN) begin
      if (strobe_eff) begin
        if (samp_w > lvl_hi) begin
          lvl_armp_d = 1'b1;
        end else if (lvl_armp_q && (samp_w <= tr_w)) begin
          lvl_fire   = 1'b1;
          lvl_armp_d = 1'b0;
        end
      end
    end else begin
      lvl_armp_d = 1'b0;
    end
    if (set_rst_i) lvl_armp_d = 1'b0;

    ext_s1_d = trig_ext_i;
    ext_s2_d = ext_s1_q;
    ext_s3_d = ext_s2_q;
    ext_rise = ext_s2_q & ~ext_s3_q;
    ext_fall = ~ext_s2_q & ext_s3_q;

    src_hit = ((trig_src_i == SRC_SW)   && trig_sw_i) ||
              ((trig_src_i == SRC_EXTP) && ext_rise)  ||
              ((trig_src_i == SRC_EXTN) && ext_fall);

    // Event triggers wait here until the next decimated sample claims them.
    pend_d = pend_q | src_hit;
    if (strobe_eff || set_rst_i) pend_d = 1'b0;

    dec_vld_d = strobe_eff;
    dec_dat_d = strobe_eff ? samp : dec_dat_q;
    dec_trg_d = strobe_eff & (pend_q | src_hit | lvl_fire);
  end

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    wp_trig_d = wp_trig_q;
    dly_d     = dly_q;
    trig_d    = 1'b0;
    we        = 1'b0;
    rdata_d   = mem[buf_addr_i];

    if (set_rst_i) begin
      state_d   = ST_IDLE;
      wp_d      = '0;
      wp_trig_d = '0;
      dly_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (set_arm_i) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (dec_vld_q) begin
            we   = 1'b1;
            wp_d = wp_q + 1'b1;
            if (dec_trg_q) begin
              wp_trig_d = wp_q;
              trig_d    = 1'b1;
              dly_d     = set_dly_i;
              state_d   = (set_dly_i == 32'd0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (dec_vld_q) begin
            we    = 1'b1;
            wp_d  = wp_q + 1'b1;
            dly_d = dly_q - 32'd1;
            if (dly_q <= 32'd1) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (set_arm_i) state_d = ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q    <= ST_IDLE;
      adc_q      <= '0;
      dec_cnt_q  <= '0;
      sum_q      <= '0;
      dec_dat_q  <= '0;
      dec_vld_q  <= 1'b0;
      dec_trg_q  <= 1'b0;
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      ext_s3_q   <= 1'b0;
      pend_q     <= 1'b0;
      lvl_armp_q <= 1'b0;
      wp_q       <= '0;
      wp_trig_q  <= '0;
      dly_q      <= '0;
      trig_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      adc_q      <= adc_d;
      dec_cnt_q  <= dec_cnt_d;
      sum_q      <= sum_d;
      dec_dat_q  <= dec_dat_d;
      dec_vld_q  <= dec_vld_d;
      dec_trg_q  <= dec_trg_d;
      ext_s1_q   <= ext_s1_d;
      ext_s2_q   <= ext_s2_d;
      ext_s3_q   <= ext_s3_d;
      pend_q     <= pend_d;
      lvl_armp_q <= lvl_armp_d;
      wp_q       <= wp_d;
      wp_trig_q  <= wp_trig_d;
      dly_q      <= dly_d;
      trig_q     <= trig_d;
      rdata_q    <= rdata_d;
    end
  end

  // Capture RAM has no reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge adc_clk_i) begin
    if (we) mem[wp_q] <= dec_dat_q;
  end

  assign buf_rdata_o = rdata_q;
  assign wp_cur_o    = wp_q;
  assign wp_trig_o   = wp_trig_q;
  assign trig_o      = trig_q;
  assign armed_o     = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_red_pitaya_acq_ch.sv
// Directed bench for red_pitaya_acq_ch: a deep (RSZ=8) and a tiny (RSZ=4) channel
// share all stimulus; buffer read-back goes through an expected-value queue.
module tb_red_pitaya_acq_ch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] adc;
  logic        sw, ext, arm, srst, avg;
  logic [2:0]  src;
  logic [16:0] dec;
  logic [13:0] tresh, hyst;
  logic [31:0] dly;
  logic [7:0]  addr_b;
  logic [3:0]  addr_s;
  logic [13:0] rdata_b, rdata_s;
  logic [7:0]  wp_cur_b, wp_trig_b;
  logic [3:0]  wp_cur_s, wp_trig_s;
  logic        trig_b, trig_s, armed_b, armed_s, done_b, done_s;

  int total = 0;
  int bad = 0;
  int trig_cnt_b = 0;
  int trig_cnt_s = 0;
  int base;

  logic [13:0] exp_q[$];
  logic [7:0]  addr_q[$];
  bit          sel_q[$];

  red_pitaya_acq_ch #(.RSZ(8)) u_big (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .adc_dat_i(adc), .trig_sw_i(sw),
    .trig_ext_i(ext), .trig_src_i(src), .set_arm_i(arm), .set_rst_i(srst),
    .set_dec_i(dec), .set_avg_i(avg), .set_tresh_i(tresh), .set_hyst_i(hyst),
    .set_dly_i(dly), .buf_addr_i(addr_b), .buf_rdata_o(rdata_b),
    .wp_cur_o(wp_cur_b), .wp_trig_o(wp_trig_b), .trig_o(trig_b),
    .armed_o(armed_b), .done_o(done_b)
  );

  red_pitaya_acq_ch #(.RSZ(4)) u_small (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .adc_dat_i(adc), .trig_sw_i(sw),
    .trig_ext_i(ext), .trig_src_i(src), .set_arm_i(arm), .set_rst_i(srst),
    .set_dec_i(dec), .set_avg_i(avg), .set_tresh_i(tresh), .set_hyst_i(hyst),
    .set_dly_i(dly), .buf_addr_i(addr_s), .buf_rdata_o(rdata_s),
    .wp_cur_o(wp_cur_s), .wp_trig_o(wp_trig_s), .trig_o(trig_s),
    .armed_o(armed_s), .done_o(done_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trig_b) trig_cnt_b++;
    if (trig_s) trig_cnt_s++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fsm_rst();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  task automatic sb_push(input bit sel, input logic [7:0] a, input logic [13:0] v);
    sel_q.push_back(sel);
    addr_q.push_back(a);
    exp_q.push_back(v);
  endtask

  // scoreboard: every queued (dut, addr) is read back and compared in order
  task automatic sb_drain();
    bit          s;
    logic [7:0]  a;
    logic [13:0] e;
    while (exp_q.size() > 0) begin
      s = sel_q.pop_front();
      a = addr_q.pop_front();
      e = exp_q.pop_front();
      if (s) addr_s = a[3:0];
      else   addr_b = a;
      step();
      if (s) check("rd_small", {18'd0, rdata_s}, {18'd0, e});
      else   check("rd_big",   {18'd0, rdata_b}, {18'd0, e});
    end
  endtask

  initial begin
    rstn = 1'b0; adc = '0; sw = 1'b0; ext = 1'b0; arm = 1'b0; srst = 1'b0;
    avg = 1'b0; src = 3'd0; dec = 17'd1; tresh = '0; hyst = '0; dly = '0;
    addr_b = '0; addr_s = '0;
    steps(3);
    check("rst_armed", {31'd0, armed_b}, 32'd0);
    check("rst_done",  {31'd0, done_b},  32'd0);
    check("rst_wp",    {24'd0, wp_cur_b}, 32'd0);
    rstn = 1'b1;
    steps(2);
    check("idle_trig",  {31'd0, trig_b | trig_s}, 32'd0);
    check("idle_rdata", {18'd0, rdata_b}, 32'd0);
    check("idle_wpt",   {28'd0, wp_trig_s}, 32'd0);
    check("idle_flags", {30'd0, armed_s, done_s}, 32'd0);

    // 1: dec=1 ramp, sw trigger on sample 100, 10 post samples
    src = 3'd1; dly = 32'd10; dec = 17'd1;
    base = trig_cnt_b;
    for (int i = 0; i < 150; i++) begin
      adc = 14'(i); arm = (i == 0); sw = (i == 101);
      step();
    end
    arm = 1'b0; sw = 1'b0;
    check("t1_wp_trig", {24'd0, wp_trig_b}, 32'd100);
    check("t1_wp_cur",  {24'd0, wp_cur_b},  32'd111);
    check("t1_done",    {30'd0, done_b, armed_b}, 32'd2);
    check("t1_trig_n",  trig_cnt_b - base, 32'd1);
    check("t1_small_wpt", {28'd0, wp_trig_s}, 32'd4);
    steps(5);
    check("t1_wp_hold", {24'd0, wp_cur_b}, 32'd111);
    sb_push(1'b0, 8'd0, 14'd0);
    sb_push(1'b0, 8'd50, 14'd50);
    sb_push(1'b0, 8'd100, 14'd100);
    sb_push(1'b0, 8'd110, 14'd110);
    sb_drain();

    // 2a: dec=8 averaging, 1000 then 1008
    fsm_rst();
    src = 3'd0; dec = 17'd8; avg = 1'b1;
    for (int i = 0; i < 84; i++) begin
      adc = (i < 40) ? 14'd1000 : 14'd1008; arm = (i == 0);
      step();
    end
    arm = 1'b0;
    fsm_rst();
    for (int k = 0; k < 5; k++) sb_push(1'b0, 8'(k), 14'd1000);
    for (int k = 5; k < 10; k++) sb_push(1'b0, 8'(k), 14'd1008);
    sb_drain();

    // 2b: dec=8 without averaging keeps the last sample of each window
    avg = 1'b0;
    for (int i = 0; i < 84; i++) begin
      adc = 14'(i); arm = (i == 0);
      step();
    end
    arm = 1'b0;
    check("t2_wp", {24'd0, wp_cur_b}, 32'd10);
    fsm_rst();
    for (int k = 0; k < 10; k += 3) sb_push(1'b0, 8'(k), 14'(8 * k + 7));
    sb_drain();

    // 3: level+ tresh=500 hyst=50; 480->520 stays quiet, 440->520 fires
    dec = 17'd1; src = 3'd2; tresh = 14'd500; hyst = 14'd50; dly = 32'd1000;
    adc = 14'd480;
    steps(3);
    fsm_rst();
    steps(2);
    base = trig_cnt_b;
    for (int i = 0; i < 40; i++) begin
      adc = (i < 10) ? 14'd480 : (i < 20) ? 14'd520 : (i < 25) ? 14'd440 : 14'd520;
      arm = (i == 0);
      step();
      if (i == 24) check("t3_no_fire", trig_cnt_b - base, 32'd0);
    end
    arm = 1'b0;
    check("t3_fire",    trig_cnt_b - base, 32'd1);
    check("t3_wp_trig", {24'd0, wp_trig_b}, 32'd25);
    check("t3_post",    {30'd0, done_b, armed_b}, 32'd1);
    sb_push(1'b0, 8'd25, 14'd520);
    sb_push(1'b0, 8'd20, 14'd440);
    sb_drain();

    // 4: ext- falling edge triggers once; a second fall in POST is ignored
    ext = 1'b1;
    steps(5);
    src = 3'd5; dly = 32'd30;
    fsm_rst();
    steps(2);
    base = trig_cnt_b;
    for (int i = 0; i < 60; i++) begin
      adc = 14'(i); arm = (i == 0);
      ext = (i < 10) ? 1'b1 : (i < 20) ? 1'b0 : (i < 25) ? 1'b1 : 1'b0;
      step();
    end
    arm = 1'b0;
    check("t4_trig_once", trig_cnt_b - base, 32'd1);
    check("t4_wp_trig",   {24'd0, wp_trig_b}, 32'd11);
    check("t4_wp_cur",    {24'd0, wp_cur_b},  32'd42);
    check("t4_done",      {31'd0, done_b}, 32'd1);

    // 5: RSZ=4 wrap, dly=20, dec=0 treated as 1
    src = 3'd1; dly = 32'd20; dec = 17'd0;
    fsm_rst();
    base = trig_cnt_s;
    for (int i = 0; i < 40; i++) begin
      adc = 14'(i); arm = (i == 0); sw = (i == 7);
      step();
    end
    arm = 1'b0; sw = 1'b0;
    check("t5_wp_trig_s", {28'd0, wp_trig_s}, 32'd6);
    check("t5_wp_cur_s",  {28'd0, wp_cur_s}, 32'((6 + 21) % 16));
    check("t5_done_s",    {31'd0, done_s}, 32'd1);
    check("t5_trig_s",    trig_cnt_s - base, 32'd1);
    check("t5_wp_cur_b",  {24'd0, wp_cur_b}, 32'd27);
    sb_push(1'b1, 8'd10, 14'd26);
    sb_push(1'b1, 8'd11, 14'd11);
    sb_push(1'b1, 8'd6, 14'd22);
    sb_drain();

    // 7: dly=0 finishes straight from ARMED on the trigger write
    dly = 32'd0; dec = 17'd1;
    fsm_rst();
    base = trig_cnt_b;
    for (int i = 0; i < 20; i++) begin
      adc = 14'(i); arm = (i == 0); sw = (i == 5);
      step();
    end
    arm = 1'b0; sw = 1'b0;
    check("t7_wp_trig", {24'd0, wp_trig_b}, 32'd4);
    check("t7_wp_cur",  {24'd0, wp_cur_b}, 32'd5);
    check("t7_done",    {30'd0, done_b, armed_b}, 32'd2);
    check("t7_trig_n",  trig_cnt_b - base, 32'd1);

    // 6: set_rst beats a simultaneous trigger, then async reset in POST
    dly = 32'd50;
    fsm_rst();
    for (int i = 0; i < 10; i++) begin
      adc = 14'(i); arm = (i == 0);
      step();
    end
    arm = 1'b0;
    base = trig_cnt_b;
    srst = 1'b1; sw = 1'b1;
    step();
    srst = 1'b0; sw = 1'b0;
    check("t6_idle",   {30'd0, done_b, armed_b}, 32'd0);
    check("t6_wp",     {24'd0, wp_cur_b}, 32'd0);
    check("t6_wp_trg", {24'd0, wp_trig_b}, 32'd0);
    steps(5);
    check("t6_no_trig", trig_cnt_b - base, 32'd0);
    check("t6_wp_idle", {24'd0, wp_cur_b}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      adc = 14'(i); arm = (i == 0); sw = (i == 5);
      step();
    end
    arm = 1'b0; sw = 1'b0;
    check("t6_post",   {30'd0, done_b, armed_b}, 32'd1);
    check("t6_trig_n", trig_cnt_b - base, 32'd1);
    check("t6_wpt",    {24'd0, wp_trig_b}, 32'd4);
    #3;
    rstn = 1'b0;
    #1;
    check("t6_ar_flags", {28'd0, armed_b, done_b, armed_s, done_s}, 32'd0);
    check("t6_ar_wp",    {8'd0, wp_cur_b, wp_trig_b, wp_cur_s, wp_trig_s}, 32'd0);
    check("t6_ar_data",  {2'd0, rdata_b, rdata_s, trig_b, trig_s}, 32'd0);
    steps(2);
    rstn = 1'b1;
    steps(2);
    check("t6_after", {30'd0, done_b, armed_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
